// File: rtl/adc_spi_scan.sv
// SPI master for an MCP3204/3208-class 12-bit ADC in single-ended mode.
// Round-robin scans channels 0..NUM_CH-1 and strobes out one sample per frame.
module adc_spi_scan #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CLK_DIV = 12,
  parameter int unsigned CS_GAP  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  output logic        adc_cs,
  output logic        adc_clk,
  output logic        adc_si,
  input  logic        adc_so,
  output logic [11:0] adc_val,
  output logic [2:0]  adc_ch,
  output logic        adc_valid
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [2:0]       CH_LAST   = 3'(NUM_CH - 1);
  localparam logic [4:0]       K_LAST    = 5'd18;
  localparam logic [4:0]       K_DATA    = 5'd7;
  localparam logic [4:0]       K_CMD_END = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [4:0]       k_q, k_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [11:0]      shift_q, shift_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             si_q, si_d;
  logic [11:0]      val_q, val_d;
  logic [2:0]       ch_q, ch_d;
  logic             valid_q, valid_d;

  // Command goes out start bit first: k=0 start, k=1 SGL, k=2..4 ch[2:0].
  function automatic logic cmd_bit(input logic [2:0] ch, input logic [4:0] k);
    logic [4:0] cmd;
    cmd = {1'b1, 1'b1, ch};
    cmd_bit = (k < K_CMD_END) ? cmd[3'(5'd4 - k)] : 1'b0;
  endfunction

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    shift_d = shift_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    si_d    = si_q;
    val_d   = val_q;
    ch_d    = ch_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        si_d  = 1'b0;
        if (ena) begin
          state_d = S_LOW;
          k_d     = '0;
          div_d   = '0;
          cs_d    = 1'b0;
          si_d    = cmd_bit(ptr_q, 5'd0);
        end
      end

      S_LOW: begin
        if (div_q == DIV_LAST) begin
          state_d = S_HIGH;
          div_d   = '0;
          sck_d   = 1'b1;
          // DOUT is captured on the clk that raises SCK, data bits only.
          if (k_q >= K_DATA) begin
            shift_d = {shift_q[10:0], adc_so};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = 1'b0;
          if (k_q == K_LAST) begin
            state_d = S_GAP;
            gap_d   = '0;
            cs_d    = 1'b1;
            si_d    = 1'b0;
            val_d   = shift_q;
            ch_d    = ptr_q;
            valid_d = 1'b1;
            ptr_d   = (ptr_q == CH_LAST) ? 3'd0 : ptr_q + 3'd1;
          end else begin
            state_d = S_LOW;
            k_d     = k_q + 5'd1;
            si_d    = cmd_bit(ptr_q, k_q + 5'd1);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_GAP: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        si_d  = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      k_q     <= '0;
      ptr_q   <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      si_q    <= 1'b0;
      val_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      si_q    <= si_d;
      val_q   <= val_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign adc_cs    = cs_q;
  assign adc_clk   = sck_q;
  assign adc_si    = si_q;
  assign adc_val   = val_q;
  assign adc_ch    = ch_q;
  assign adc_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_scan.sv
// Bench for adc_spi_scan: MCP3208-style responder, SPI timing monitor,
// table of expected scan results and hand-written enable/reset sequences.
`timescale 1ns/1ps
module tb_adc_spi_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ena = 1'b0;
  logic        adc_cs, adc_clk, adc_si, adc_so, adc_valid;
  logic [11:0] adc_val;
  logic [2:0]  adc_ch;
  logic        loop_mode = 1'b0;
  logic        model_so = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_valid_cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  assign adc_so = loop_mode ? adc_si : model_so;

  adc_spi_scan #(.NUM_CH(4), .CLK_DIV(12), .CS_GAP(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .adc_cs    (adc_cs),
    .adc_clk   (adc_clk),
    .adc_si    (adc_si),
    .adc_so    (adc_so),
    .adc_val   (adc_val),
    .adc_ch    (adc_ch),
    .adc_valid (adc_valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ADC responder: decodes the channel from DIN, drives DOUT on SCK falling edges.
  logic [4:0]  m_bits = '0;
  int          m_r = 0;
  logic [2:0]  m_ch = '0;
  logic [11:0] m_val = '0;

  always @(negedge adc_cs) begin
    m_r = 0;
    model_so = 1'b0;
  end

  always @(posedge adc_clk) begin
    if (m_r < 5) m_bits[m_r] = adc_si;
    m_r++;
    if (m_r == 5) begin
      m_ch  = {m_bits[2], m_bits[3], m_bits[4]};
      m_val = 12'h100 * m_ch + 12'h023;
    end
  end

  always @(negedge adc_clk) begin
    model_so = (m_r >= 7 && m_r <= 18) ? m_val[18 - m_r] : 1'b0;
  end

  // SPI timing monitor, sampled on the falling clk edge.
  bit mon_en = 1'b0;
  bit prev_cs = 1'b1, prev_sck = 1'b0, gap_ok = 1'b0;
  int run = 0, rises = 0, gap_run = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_cs = adc_cs; prev_sck = adc_clk;
      run = 0; rises = 0; gap_run = 0; gap_ok = 1'b0;
    end else begin
      if (prev_cs && !adc_cs) begin
        if (gap_ok) chk("cs_gap_ge24", int'(gap_run >= 24), 1);
        run = 1;
        rises = 0;
      end else if (!prev_cs) begin
        if (adc_clk != prev_sck) begin
          chk("sck_half_period", run, 12);
          run = 1;
          if (adc_clk) begin
            if (rises < 2) chk("si_start_sgl", adc_si, 1);
            if (rises >= 5) chk("si_tail_zero", adc_si, 0);
            rises++;
          end
        end else begin
          run++;
        end
        if (adc_cs) begin
          chk("sck_rises_per_frame", rises, 19);
          gap_run = 1;
          gap_ok = 1'b1;
        end
      end else begin
        gap_run++;
      end
      prev_cs = adc_cs;
      prev_sck = adc_clk;
    end
  end

  task automatic wait_valid(input string name, input int exp_ch, input int exp_val,
                            input int exp_gap);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (adc_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, seen, 1);
    if (seen) begin
      chk({name, "_ch"}, adc_ch, exp_ch);
      chk({name, "_val"}, adc_val, exp_val);
      chk({name, "_si_ch"}, m_ch, exp_ch);
      if (exp_gap > 0) chk({name, "_interval"}, cyc - last_valid_cyc, exp_gap);
      last_valid_cyc = cyc;
      @(negedge clk);
      chk({name, "_one_clk"}, adc_valid, 0);
    end
  endtask

  // Returns while SCK is high in bit k = n-1 of the next frame.
  task automatic wait_k(input int n);
    bit ok, ps;
    int cnt;
    ok = 1'b0; cnt = 0;
    for (int i = 0; i < 600 && adc_cs; i++) @(negedge clk);
    ps = adc_clk;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (adc_clk && !ps) cnt++;
      ps = adc_clk;
      if (cnt == n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_k_reached", ok, 1);
  endtask

  typedef struct {
    bit loopback;
    int ch;
    int val;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int vcnt, lowcnt;

    vecs[0]  = '{1'b0, 0, 'h023};
    vecs[1]  = '{1'b0, 1, 'h123};
    vecs[2]  = '{1'b0, 2, 'h223};
    vecs[3]  = '{1'b0, 3, 'h323};
    vecs[4]  = '{1'b0, 0, 'h023};
    vecs[5]  = '{1'b0, 1, 'h123};
    vecs[6]  = '{1'b0, 2, 'h223};
    vecs[7]  = '{1'b0, 3, 'h323};
    vecs[8]  = '{1'b1, 0, 'h000};
    vecs[9]  = '{1'b1, 1, 'h000};
    vecs[10] = '{1'b1, 2, 'h000};
    vecs[11] = '{1'b1, 3, 'h000};

    // Reset held ~1 us with ena low.
    vcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (adc_valid) vcnt++;
    end
    chk("rst_valid_pulses", vcnt, 0);
    chk("rst_cs", adc_cs, 1);
    chk("rst_sck", adc_clk, 0);
    chk("rst_si", adc_si, 0);
    chk("rst_val", adc_val, 0);
    chk("rst_ch", adc_ch, 0);
    chk("rst_valid", adc_valid, 0);

    reset = 1'b0;
    vcnt = 0; lowcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (adc_valid) vcnt++;
      if (!adc_cs) lowcnt++;
    end
    chk("idle_valid_pulses", vcnt, 0);
    chk("idle_cs_low_clks", lowcnt, 0);

    mon_en = 1'b1;
    ena = 1'b1;
    for (int i = 0; i < 12; i++) begin
      loop_mode = vecs[i].loopback;
      wait_valid($sformatf("scan%0d", i), vecs[i].ch, vecs[i].val, (i > 0) ? 481 : 0);
    end
    loop_mode = 1'b0;

    // ena dropped mid-frame (k=9 of ch0 after the loopback run).
    wait_k(10);
    ena = 1'b0;
    wait_valid("drop", 0, 'h023, 481);
    vcnt = 0; lowcnt = 0;
    repeat (700) begin
      @(negedge clk);
      if (adc_valid) vcnt++;
      if (!adc_cs) lowcnt++;
    end
    chk("parked_valid_pulses", vcnt, 0);
    chk("parked_cs_low_clks", lowcnt, 0);
    ena = 1'b1;
    wait_valid("resume", 1, 'h123, 0);
    wait_valid("resume_next", 2, 'h223, 481);

    // Reset pulsed at k=12 of the ch3 frame.
    wait_k(13);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs", adc_cs, 1);
    chk("midrst_sck", adc_clk, 0);
    chk("midrst_si", adc_si, 0);
    chk("midrst_val", adc_val, 0);
    chk("midrst_ch", adc_ch, 0);
    chk("midrst_valid", adc_valid, 0);
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (adc_valid) vcnt++;
    end
    chk("midrst_valid_pulses", vcnt, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    wait_valid("post_rst", 0, 'h023, 0);
    wait_valid("post_rst_next", 1, 'h123, 481);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
